ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//   Instruction-fetch stage of the NPC core. Owns the PC register, issues one
//   fetch request at a time to instruction memory, and captures the returned
//   instruction. Presents {pc, inst} downstream to the decode/execute stage via
//   valid/ready. Accepts a PC redirect (branch/jump/trap) from downstream.
// PARAMETERS
//   XLEN      32            address/data width
//   RESET_PC  32'h8000_0000 PC loaded while rst_n=0
// PORTS
//   clk            in   1     clock, all state updates on posedge
//   rst_n          in   1     synchronous, active-low reset
//   imem_req_valid out  1     fetch request valid
//   imem_req_ready in   1     memory accepts request
//   imem_req_addr  out  XLEN  fetch address (= pc)
//   imem_rsp_valid in   1     response valid
//   imem_rsp_ready out  1     fetch stage accepts response
//   imem_rsp_data  in   32    fetched instruction
//   redirect_valid in   1     downstream requests PC change
//   redirect_pc    in   XLEN  new PC; bits [1:0] ignored, forced 2'b00
//   inst_valid     out  1     {inst_pc, inst} valid to downstream
//   inst_ready     in   1     downstream accepts
//   inst_pc        out  XLEN  PC of presented instruction
//   inst           out  32    presented instruction
// BEHAVIOUR
//   One clock; reset synchronous, active-low: clk/rst_n. rst_n=0 at a posedge
//   -> state=IDLE, pc=RESET_PC, inst/inst_pc=0. All outputs are decoded from
//   registered state: while IDLE, imem_req_valid=imem_rsp_ready=inst_valid=0.
//   States: IDLE, REQ, WAIT, DROP, HOLD.
//   - IDLE: unconditional -> REQ next cycle (first request 1 cycle after reset).
//   - REQ : imem_req_valid=1, addr=pc. req_ready=1 -> WAIT. addr stable until accepted.
//   - WAIT: imem_rsp_ready=1. rsp_valid=1 -> capture inst=rsp_data,
//           inst_pc=pc -> HOLD.
//   - HOLD: inst_valid=1, inst/inst_pc stable. inst_ready=1 -> pc<=pc+4 -> REQ.
//   - DROP: imem_rsp_ready=1; rsp_valid=1 -> discard data -> REQ.
//   Redirect (priority over normal next-state, except as noted):
//   - IDLE: ignored (next state REQ, pc unchanged).
//   - REQ : pc<=redirect_pc; if req_ready same cycle -> DROP, else stay REQ
//           (pc/addr change is legal only because the request was not accepted).
//   - WAIT: pc<=redirect_pc; rsp_valid same cycle -> REQ, else -> DROP.
//   - HOLD: pc<=redirect_pc -> REQ; held inst discarded. If inst_ready is also
//           1 the handshake still completes (downstream consumed it).
//   - DROP: pc<=redirect_pc, remain DROP until outstanding rsp returns.
//   At most one outstanding request. Earliest response is the cycle after
//   request acceptance; rsp_valid outside WAIT/DROP is a protocol violation
//   (ignored, flagged by assertion). pc+4 wraps modulo 2^XLEN.
//   Latency: req accept -> rsp (>=1 cycle) -> inst_valid next cycle.
//   Peak throughput: 1 inst / 3 cycles with zero-wait memory and inst_ready=1.
//   rst_n=0 mid-transaction: immediate return to IDLE, pending rsp dropped by
//   memory-side reset; no output glitch beyond the reset cycle.
// STRUCTURE
//   npc_pkg: XLEN, RESET_PC, ifu_state_e {IDLE,REQ,WAIT,DROP,HOLD}.
//   pc, inst, inst_pc built from the shared parametric register cell
//   (reset val, write enable); FSM is a single always block in this file.
// TESTING
//   1 Reset: hold rst_n=0 3 cycles -> all valids 0; release -> REQ next cycle,
//     addr=32'h8000_0000.
//   2 Stream: mem ready=1, rsp 1 cycle later; inst_ready=1 -> inst_pc
//     8000_0000,_0004,_0008 every 3 cycles, inst matches memory image.
//   3 Backpressure: inst_ready=0 5 cycles in HOLD -> inst/inst_pc stable,
//     no new request; ready=1 -> next addr 8000_0004.
//   4 Redirect in WAIT: redirect_pc=8000_0103 before rsp -> DROP, rsp
//     discarded (inst_valid stays 0), next req addr 8000_0100.
//   5 Redirect+handshake in HOLD same cycle -> transfer counted, next addr
//     = redirect_pc; redirect in REQ with req_ready=0 -> addr switches,
//     stays REQ.
//   6 Wrap: redirect to FFFF_FFFC, consume -> next addr 0000_0000.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core front end.
package npc_pkg;

  localparam int              XLEN     = 32;
  localparam int              ILEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  // Fetch stage sequencing: one request in flight at most.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HOLD
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_reg.sv
// Parametric register cell: synchronous active-low reset to a fixed value,
// load on write enable, otherwise hold.
module ifu_fetch_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Reset wins over write enable; value held when not written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_o <= RST_VAL;
    end else if (we_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time, holds the
// returned instruction for downstream, and honours PC redirects.
module ifu_fetch #(
  parameter int                XLEN     = npc_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_PC = npc_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst
);

  import npc_pkg::*;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inst_pc_q;
  logic [31:0]     inst_q;
  logic            pc_we;
  logic            cap_we;
  logic [XLEN-1:0] redir_pc_aligned;
  logic            unused_redir_lsb;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign redir_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, PC update and capture decisions; redirect outranks normal flow.
  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    pc_d    = pc_q;
    cap_we  = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // Changing the address is safe only because it was not yet accepted;
        // if it is accepted together with a redirect the reply is stale.
        if (redirect_valid) begin
          pc_we = 1'b1;
          pc_d  = redir_pc_aligned;
        end
        if (imem_req_ready) begin
          state_d = redirect_valid ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_d    = redir_pc_aligned;
          state_d = imem_rsp_valid ? REQ : DROP;
        end else if (imem_rsp_valid) begin
          cap_we  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_we   = 1'b1;
          pc_d    = redir_pc_aligned;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_we   = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      DROP: begin
        // Stale reply still owed by memory; keep tracking newer redirects.
        if (redirect_valid) begin
          pc_we = 1'b1;
          pc_d  = redir_pc_aligned;
        end
        if (imem_rsp_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  ifu_fetch_reg #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (pc_we),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  ifu_fetch_reg #(.W(32), .RST_VAL('0)) u_inst_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (cap_we),
    .d_i   (imem_rsp_data),
    .q_o   (inst_q)
  );

  ifu_fetch_reg #(.W(XLEN), .RST_VAL('0)) u_inst_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (cap_we),
    .d_i   (pc_q),
    .q_o   (inst_pc_q)
  );

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = (state_q == WAIT) || (state_q == DROP);
  assign inst_valid     = (state_q == HOLD);
  assign inst_pc        = inst_pc_q;
  assign inst           = inst_q;

  // Memory must only answer while a request is outstanding.
  rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((state_q == WAIT) || (state_q == DROP))
  );

endmodule
